// File: rtl/bullet_pool_sequencer_pkg.sv
// Shared definitions for the bullet pipeline (sequencer and plotter).
//   SCREEN_W / SCREEN_H : visible raster size in pixels
//   X_W / Y_W           : coordinate widths
//   BULLET_H            : bullet sprite height; the plotter draws rows y..y-(BULLET_H-1)
//   seq_state_t         : sequencer FSM states
//   clamp_base_y        : raises a spawn y to the smallest legal base y
package bullet_pool_sequencer_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int BULLET_H = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE_SC,
        S_ERASE_WT,
        S_MOVE,
        S_DRAW_SC,
        S_DRAW_WT
    } seq_state_t;

    function automatic logic [Y_W-1:0] clamp_base_y(input logic [Y_W-1:0] y,
                                                     input logic [Y_W-1:0] y_min);
        return (y < y_min) ? y_min : y;
    endfunction

endpackage

// File: rtl/bullet_pool_sequencer_slot_finder.sv
// bullet_slot_finder: combinational slot encoders for the bullet pool.
//   scan_mask  : slots that still need plotting
//   scan_start : lowest slot index to consider
//   scan_found / scan_idx : lowest set bit of scan_mask at or above scan_start
//   used_mask  : slots that are occupied
//   free_found / free_idx : lowest clear bit of used_mask
module bullet_slot_finder #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     scan_mask,
    input  logic [IDX_W-1:0] scan_start,
    output logic             scan_found,
    output logic [IDX_W-1:0] scan_idx,
    input  logic [N-1:0]     used_mask,
    output logic             free_found,
    output logic [IDX_W-1:0] free_idx
);

    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!scan_found && scan_mask[i] && (i >= 32'(scan_start))) begin
                scan_found = 1'b1;
                scan_idx   = IDX_W'(i);
            end
            if (!free_found && !used_mask[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bullet_pool_sequencer.sv
// bullet_pool_sequencer: owns the live player bullets and, once per frame, erases them,
// moves them up, retires those past the top, spawns one pending fire, and redraws them.
// Each erase/draw is a single plotter transaction over plot_en / plot_done.
//   clk, resetn            : clock, async active-low reset
//   frame_tick             : 1-cycle pulse starting a frame update
//   fire, fire_x, fire_y   : 1-cycle spawn request with its position
//   kill_valid, kill_idx   : retire a slot (collision)
//   plot_done              : plotter done (high while plot_en is low)
//   plot_en/x/y/colour     : registered plotter request (colour 1 = draw, 0 = erase)
//   active_mask            : slot valid bits
//   busy                   : frame update in progress
//   overrun                : sticky, frame_tick seen while busy
module bullet_pool_sequencer
    import bullet_pool_sequencer_pkg::*;
#(
    parameter  int NUM_BULLETS = 4,
    parameter  int Y_STEP      = 2,
    parameter  int Y_MIN       = 3,
    localparam int IDX_W       = $clog2(NUM_BULLETS)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   frame_tick,
    input  logic                   fire,
    input  logic [X_W-1:0]         fire_x,
    input  logic [Y_W-1:0]         fire_y,
    input  logic                   kill_valid,
    input  logic [IDX_W-1:0]       kill_idx,
    input  logic                   plot_done,
    output logic                   plot_en,
    output logic [X_W-1:0]         plot_x,
    output logic [Y_W-1:0]         plot_y,
    output logic                   plot_colour,
    output logic [NUM_BULLETS-1:0] active_mask,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [Y_W-1:0]   RETIRE_BELOW = Y_W'(Y_MIN + Y_STEP);
    localparam logic [Y_W-1:0]   STEP         = Y_W'(Y_STEP);
    localparam logic [Y_W-1:0]   MIN_Y        = Y_W'(Y_MIN);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_BULLETS - 1);

    seq_state_t             state, state_d;
    logic [IDX_W-1:0]       idx, idx_d;
    logic                   plot_en_d, plot_colour_d, overrun_d;
    logic [X_W-1:0]         plot_x_d;
    logic [Y_W-1:0]         plot_y_d;
    logic [NUM_BULLETS-1:0] valid, valid_d, survive;
    logic [X_W-1:0]         slot_x   [NUM_BULLETS];
    logic [X_W-1:0]         slot_x_d [NUM_BULLETS];
    logic [Y_W-1:0]         slot_y   [NUM_BULLETS];
    logic [Y_W-1:0]         slot_y_d [NUM_BULLETS];
    logic                   pend_valid, pend_valid_d;
    logic [X_W-1:0]         pend_x, pend_x_d;
    logic [Y_W-1:0]         pend_y, pend_y_d;

    logic                   scan_found, free_found;
    logic [IDX_W-1:0]       scan_idx, free_idx;

    // Slots still alive after this frame's retirement; the spawn slot is chosen from these.
    always_comb begin
        survive = valid;
        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            if (slot_y[i] < RETIRE_BELOW) survive[i] = 1'b0;
        end
    end

    bullet_slot_finder #(.N(NUM_BULLETS)) u_finder (
        .scan_mask  (valid),
        .scan_start (idx),
        .scan_found (scan_found),
        .scan_idx   (scan_idx),
        .used_mask  (survive),
        .free_found (free_found),
        .free_idx   (free_idx)
    );

    always_comb begin
        state_d       = state;
        idx_d         = idx;
        plot_en_d     = plot_en;
        plot_x_d      = plot_x;
        plot_y_d      = plot_y;
        plot_colour_d = plot_colour;
        valid_d       = valid;
        slot_x_d      = slot_x;
        slot_y_d      = slot_y;
        pend_valid_d  = pend_valid;
        pend_x_d      = pend_x;
        pend_y_d      = pend_y;
        overrun_d     = overrun | (frame_tick && (state != S_IDLE));

        case (state)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = S_ERASE_SC;
                    idx_d   = '0;
                end
            end
            S_ERASE_SC, S_DRAW_SC: begin
                if (scan_found) begin
                    idx_d         = scan_idx;
                    plot_x_d      = slot_x[scan_idx];
                    plot_y_d      = slot_y[scan_idx];
                    plot_colour_d = (state == S_DRAW_SC);
                    plot_en_d     = 1'b1;
                    state_d       = (state == S_DRAW_SC) ? S_DRAW_WT : S_ERASE_WT;
                end else begin
                    state_d = (state == S_DRAW_SC) ? S_IDLE : S_MOVE;
                end
            end
            S_ERASE_WT, S_DRAW_WT: begin
                if (plot_en && plot_done) begin
                    plot_en_d = 1'b0;
                    if (idx == LAST_IDX) begin
                        state_d = (state == S_DRAW_WT) ? S_IDLE : S_MOVE;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        state_d = (state == S_DRAW_WT) ? S_DRAW_SC : S_ERASE_SC;
                    end
                end
            end
            S_MOVE: begin
                valid_d = survive;
                for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
                    if (survive[i]) slot_y_d[i] = slot_y[i] - STEP;
                end
                if (pend_valid) begin
                    pend_valid_d = 1'b0;
                    if (free_found) begin
                        valid_d[free_idx]  = 1'b1;
                        slot_x_d[free_idx] = pend_x;
                        slot_y_d[free_idx] = clamp_base_y(pend_y, MIN_Y);
                    end
                end
                idx_d   = '0;
                state_d = S_DRAW_SC;
            end
            default: state_d = S_IDLE;
        endcase

        // A fire in the MOVE cycle is newer than the one consumed there, so it stays pending.
        if (fire) begin
            pend_valid_d = 1'b1;
            pend_x_d     = fire_x;
            pend_y_d     = fire_y;
        end
        // Applied last so a kill overrides the MOVE update and spawn for the same slot.
        if (kill_valid) valid_d[kill_idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            idx         <= '0;
            plot_en     <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= 1'b0;
            overrun     <= 1'b0;
            valid       <= '0;
            pend_valid  <= 1'b0;
            pend_x      <= '0;
            pend_y      <= '0;
            for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
            end
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            plot_en     <= plot_en_d;
            plot_x      <= plot_x_d;
            plot_y      <= plot_y_d;
            plot_colour <= plot_colour_d;
            overrun     <= overrun_d;
            valid       <= valid_d;
            pend_valid  <= pend_valid_d;
            pend_x      <= pend_x_d;
            pend_y      <= pend_y_d;
            slot_x      <= slot_x_d;
            slot_y      <= slot_y_d;
        end
    end

    assign active_mask = valid;
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_bullet_pool_sequencer.sv
module tb_bullet_pool_sequencer;

    localparam int N  = 4;
    localparam int YS = 2;
    localparam int YM = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       fire = 1'b0;
    logic [8:0] fire_x = '0;
    logic [7:0] fire_y = '0;
    logic       kill_valid = 1'b0;
    logic [1:0] kill_idx = '0;
    logic       plot_done;
    logic       plot_en;
    logic [8:0] plot_x;
    logic [7:0] plot_y;
    logic       plot_colour;
    logic [3:0] active_mask;
    logic       busy;
    logic       overrun;

    bullet_pool_sequencer #(.NUM_BULLETS(N), .Y_STEP(YS), .Y_MIN(YM)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .fire        (fire),
        .fire_x      (fire_x),
        .fire_y      (fire_y),
        .kill_valid  (kill_valid),
        .kill_idx    (kill_idx),
        .plot_done   (plot_done),
        .plot_en     (plot_en),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .active_mask (active_mask),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Plotter stand-in: done low while busy, random latency per transaction.
    int pcnt = 0;
    int plat = 2;
    always @(posedge clk) begin
        if (!plot_en) begin
            pcnt <= 0;
            plat <= int'($urandom_range(1, 4));
        end else begin
            pcnt <= pcnt + 1;
        end
    end
    assign plot_done = !plot_en || (pcnt >= plat);

    // Transaction monitor: records completed plots, counts enable pulses and hold violations.
    logic [17:0] obs_q[$];
    int          en_rises = 0;
    int          hold_errs = 0;
    logic        prev_en = 1'b0;
    logic [17:0] prev_tuple = '0;
    always @(negedge clk) begin
        if (resetn) begin
            if (plot_en && !prev_en) en_rises++;
            if (plot_en && prev_en && ({plot_colour, plot_x, plot_y} !== prev_tuple)) hold_errs++;
            if (plot_en && plot_done) obs_q.push_back({plot_colour, plot_x, plot_y});
        end
        prev_en    = plot_en;
        prev_tuple = {plot_colour, plot_x, plot_y};
    end

    // Reference model of the bullet pool.
    bit          mv[N];
    logic [8:0]  mx[N];
    logic [7:0]  my[N];
    bit          mpend;
    logic [8:0]  mpx;
    logic [7:0]  mpy;
    logic [17:0] exp_q[$];

    function automatic logic [3:0] model_mask();
        logic [3:0] m;
        for (int i = 0; i < N; i++) m[i] = mv[i];
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0; mx[i] = '0; my[i] = '0;
        end
        mpend = 0;
    endtask

    // Builds the expected plot list for one frame and advances the model.
    task automatic model_frame();
        int free_slot;
        exp_q.delete();
        for (int i = 0; i < N; i++)
            if (mv[i]) exp_q.push_back({1'b0, mx[i], my[i]});
        for (int i = 0; i < N; i++) begin
            if (mv[i]) begin
                if (int'(my[i]) - YS < YM) mv[i] = 0;
                else my[i] = 8'(int'(my[i]) - YS);
            end
        end
        if (mpend) begin
            free_slot = -1;
            for (int i = N - 1; i >= 0; i--) if (!mv[i]) free_slot = i;
            if (free_slot >= 0) begin
                mv[free_slot] = 1;
                mx[free_slot] = mpx;
                my[free_slot] = (int'(mpy) < YM) ? 8'(YM) : mpy;
            end
            mpend = 0;
        end
        for (int i = 0; i < N; i++)
            if (mv[i]) exp_q.push_back({1'b1, mx[i], my[i]});
    endtask

    task automatic do_fire(input logic [8:0] x, input logic [7:0] y);
        @(negedge clk);
        fire = 1'b1; fire_x = x; fire_y = y;
        @(negedge clk);
        fire = 1'b0;
        mpend = 1; mpx = x; mpy = y;
    endtask

    task automatic do_kill(input int k);
        @(negedge clk);
        kill_valid = 1'b1; kill_idx = 2'(k);
        @(negedge clk);
        kill_valid = 1'b0;
        mv[k] = 0;
    endtask

    // Runs one frame, optionally killing slot kslot while the erase of x=kx is in flight,
    // injecting a frame_tick during erase, or a fire during draw.
    task automatic run_frame(input string name, input bit kill_en, input int kslot,
                             input logic [8:0] kx, input bit tick_inj, input bit fire_inj,
                             input logic [8:0] fx, input logic [7:0] fy);
        int o0 = obs_q.size();
        int r0 = en_rises;
        int h0 = hold_errs;
        int cyc = 0;
        int n_obs;
        bit killed = 0, ticked = 0, fired = 0;
        if (kill_en) mv[kslot] = 0;
        model_frame();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        while (busy && cyc < 3000) begin
            kill_valid = 1'b0; fire = 1'b0; frame_tick = 1'b0;
            if (kill_en && !killed && plot_en && !plot_colour && plot_x == kx) begin
                kill_valid = 1'b1; kill_idx = 2'(kslot); killed = 1;
            end
            if (tick_inj && !ticked && plot_en && !plot_colour) begin
                frame_tick = 1'b1; ticked = 1;
            end
            if (fire_inj && !fired && plot_en && plot_colour) begin
                fire = 1'b1; fire_x = fx; fire_y = fy; fired = 1;
            end
            @(negedge clk);
            cyc++;
        end
        kill_valid = 1'b0; fire = 1'b0; frame_tick = 1'b0;
        if (fired) begin
            mpend = 1; mpx = fx; mpy = fy;
        end
        checks++;
        if (cyc >= 3000) begin
            errors++; $display("FAIL %s frame_timeout: busy still %b after %0d cycles, required 0", name, busy, cyc);
        end
        n_obs = obs_q.size() - o0;
        checks++;
        if (n_obs != exp_q.size()) begin
            errors++; $display("FAIL %s plot_count: got %0d, expected %0d", name, n_obs, exp_q.size());
        end
        for (int i = 0; i < n_obs && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[o0 + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s plot[%0d]: got c=%0d x=%0d y=%0d, expected c=%0d x=%0d y=%0d",
                         name, i, obs_q[o0+i][17], obs_q[o0+i][16:8], obs_q[o0+i][7:0],
                         exp_q[i][17], exp_q[i][16:8], exp_q[i][7:0]);
            end
        end
        checks++;
        if (en_rises - r0 != exp_q.size()) begin
            errors++; $display("FAIL %s plot_en_pulses: got %0d, expected %0d", name, en_rises - r0, exp_q.size());
        end
        checks++;
        if (hold_errs != h0) begin
            errors++; $display("FAIL %s plot_hold: %0d request changes while plot_en high, expected 0", name, hold_errs - h0);
        end
        checks++;
        if (active_mask !== model_mask()) begin
            errors++; $display("FAIL %s active_mask: got %b, expected %b", name, active_mask, model_mask());
        end
        if (kill_en || tick_inj || fire_inj) begin
            checks++;
            if ((kill_en && !killed) || (tick_inj && !ticked) || (fire_inj && !fired)) begin
                errors++; $display("FAIL %s injection_window: kill=%0d tick=%0d fire=%0d, expected all requested", name, killed, ticked, fired);
            end
        end
    endtask

    task automatic frame(input string name);
        run_frame(name, 0, 0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        checks++;
        if ({plot_en, plot_x, plot_y, plot_colour, active_mask, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b x=%0d y=%0d c=%b mask=%b busy=%b ovr=%b, expected all 0",
                     plot_en, plot_x, plot_y, plot_colour, active_mask, busy, overrun);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_spawn_and_move();
        do_fire(9'd100, 8'd200);
        frame("spawn");
        frame("move");
    endtask

    task automatic test_retire_and_clamp();
        test_reset();
        do_fire(9'd50, 8'd4);
        frame("spawn_y4");
        frame("retire_y4");
        do_fire(9'd60, 8'd5);
        frame("spawn_y5");
        frame("move_y5_to_3");
        frame("retire_y3");
        do_fire(9'd70, 8'd1);
        frame("clamp_spawn");
        checks++;
        if (obs_q[obs_q.size()-1] !== {1'b1, 9'd70, 8'(YM)}) begin
            errors++; $display("FAIL clamp_value: got y=%0d, expected %0d", obs_q[obs_q.size()-1][7:0], YM);
        end
    endtask

    task automatic test_full_pool();
        test_reset();
        for (int i = 0; i < N; i++) begin
            do_fire(9'(10 * (i + 1)), 8'(200 - 10 * i));
            frame("fill");
        end
        do_fire(9'd300, 8'd230);
        frame("drop_when_full");
    endtask

    task automatic test_kill_midframe();
        run_frame("kill_slot2", 1, 2, mx[1], 0, 0, '0, '0);
    endtask

    task automatic test_overrun_and_late_fire();
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_pre: got %b, expected 0", overrun);
        end
        run_frame("overrun_late_fire", 0, 0, '0, 1, 1, 9'd222, 8'd150);
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_set: got %b, expected 1", overrun);
        end
        frame("late_fire_loaded");
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky: got %b, expected 1", overrun);
        end
    endtask

    task automatic test_random();
        int nf;
        test_reset();
        for (int it = 0; it < 25; it++) begin
            nf = int'($urandom_range(0, 2));
            for (int f = 0; f < nf; f++) begin
                if ($urandom_range(0, 3) == 0) do_fire(9'($urandom_range(0, 319)), 8'($urandom_range(0, 8)));
                else do_fire(9'($urandom_range(0, 319)), 8'($urandom_range(0, 239)));
            end
            if ($urandom_range(0, 3) == 0) do_kill(int'($urandom_range(0, N - 1)));
            frame("random");
        end
    endtask

    task automatic test_reset_midframe();
        int cyc = 0;
        do_fire(9'd33, 8'd120);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        while (!plot_en && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!plot_en) begin
            errors++; $display("FAIL midframe_plot_start: got plot_en=%b, expected 1", plot_en);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({plot_en, active_mask, busy} !== '0) begin
            errors++; $display("FAIL async_reset: en=%b mask=%b busy=%b, expected all 0", plot_en, active_mask, busy);
        end
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_spawn_and_move();
        test_retire_and_clamp();
        test_full_pool();
        test_kill_midframe();
        test_overrun_and_late_fire();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
